// File: rtl/ic7420_tester_pkg.sv
// Shared types and helpers for the 7420 dual 4-input NAND tester.
// Holds the FSM state encoding, the vector count and the functions that
// give the expected gate outputs for a given vector index.
package ic7420_tester_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 16;

    // Gate 1 sees the vector itself, so it only goes low at v = 4'hF.
    function automatic logic exp_p1y(input logic [3:0] v);
        return ~&v;
    endfunction

    // Gate 2 sees the inverted vector, so it only goes low at v = 4'h0.
    function automatic logic exp_p2y(input logic [3:0] v);
        return ~&(~v);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-stage flop synchronizer for signals arriving asynchronously to clk.
// Ports:
//   clk    - sampling clock, rising edge
//   reset  - asynchronous active-high reset, clears every stage to 0
//   d      - asynchronous input bus
//   q      - synchronized output, STAGES cycles behind d
module bit_sync
    import ic7420_tester_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int WIDTH  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Plain shift chain; stage 0 is the only flop that may go metastable,
    // later stages give it time to resolve before the value is used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ic7420_tester.sv
// Drive-and-check tester for a 7420 dual 4-input NAND.
// A run steps a 4-bit vector 0..15: gate 1 gets the vector, gate 2 gets its
// inverse. After each vector settles, the synchronized chip outputs are
// compared with the ideal NAND result and errors are tallied.
// Ports:
//   clk, reset          - clock (rising edge) and async active-high reset
//   start               - level request; only looked at while idle
//   p1a..p1d, p2a..p2d  - registered drive to the chip inputs
//   p1y, p2y            - chip outputs, asynchronous to clk
//   busy                - high from the first DRIVE through the last CHECK
//   done                - one-cycle pulse when a run finishes
//   pass                - no failing vectors in the last run
//   err_count           - number of failing vectors (0..16)
//   fail_vec, fail_y    - index and sampled {p2y,p1y} of the first failure
module ic7420_tester
    import ic7420_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       p1a,
    output logic       p1b,
    output logic       p1c,
    output logic       p1d,
    output logic       p2a,
    output logic       p2b,
    output logic       p2c,
    output logic       p2d,
    input  logic       p1y,
    input  logic       p2y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] fail_vec,
    output logic [1:0] fail_y
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_VEC = 4'(NUM_VECTORS - 1);

    state_t        state;
    logic [3:0]    vec;
    logic [CW-1:0] settle_cnt;
    logic [1:0]    y_sync;
    logic [1:0]    y_exp;
    logic          mismatch;
    logic [4:0]    err_next;

    bit_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (2)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({p2y, p1y}),
        .q     (y_sync)
    );

    // Expected outputs for the vector currently on the pins, and the error
    // count as it would be after this vector is judged.
    always_comb begin
        y_exp    = {exp_p2y(vec), exp_p1y(vec)};
        mismatch = (y_sync != y_exp);
        err_next = err_count + {4'b0000, mismatch};
    end

    // Single-process FSM: sequencing, pin drive and result registers.
    // Pins change on the edge leaving DRIVE and then sit for SETTLE_CYCLES
    // so the synchronizer is flushed before CHECK looks at y_sync.
    // pass is resolved on the last CHECK so it is valid alongside done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            {p1a, p1b, p1c, p1d} <= 4'b0000;
            {p2a, p2b, p2c, p2d} <= 4'b0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= DRIVE;
                        vec       <= '0;
                        err_count <= '0;
                        fail_vec  <= '0;
                        fail_y    <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                DRIVE: begin
                    {p1a, p1b, p1c, p1d} <= vec;
                    {p2a, p2b, p2c, p2d} <= ~vec;
                    settle_cnt <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_next;
                        if (err_count == 5'd0) begin
                            fail_vec <= vec;
                            fail_y   <= y_sync;
                        end
                    end
                    if (vec == LAST_VEC) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (err_next == 5'd0);
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ic7420_tester.sv
// Self-checking bench for ic7420_tester.
// A behavioural 7420 with selectable faults sits on the chip pins. Each
// table entry names a fault mode and the result the tester must report;
// entries are pushed to a scoreboard queue at start and popped on done.
module tb_ic7420_tester;

    typedef struct {
        int         mode;
        string      name;
        logic [4:0] err;
        logic [3:0] fvec;
        logic [1:0] fy;
        logic       pass;
    } run_t;

    localparam int RUN_CYCLES = 96;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       p1a, p1b, p1c, p1d, p2a, p2b, p2c, p2d;
    logic       p1y, p2y;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] fail_vec;
    logic [1:0] fail_y;

    int   fault_mode = 0;
    int   total = 0;
    int   bad = 0;
    run_t exp_q[$];
    run_t runs[6];
    int   done_q[$];

    ic7420_tester #(
        .SETTLE_CYCLES (4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .p1a       (p1a),
        .p1b       (p1b),
        .p1c       (p1c),
        .p1d       (p1d),
        .p2a       (p2a),
        .p2b       (p2b),
        .p2c       (p2c),
        .p2d       (p2d),
        .p1y       (p1y),
        .p2y       (p2y),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec),
        .fail_y    (fail_y)
    );

    always #5 clk = ~clk;

    // Chip model: 0 ideal, 1 p1y stuck-at-1, 2 p2y stuck-at-0,
    // 3 outputs swapped, 4 p1y inverted only when gate 1 sees 4'h7.
    always_comb begin
        logic n1, n2;
        n1 = ~&{p1a, p1b, p1c, p1d};
        n2 = ~&{p2a, p2b, p2c, p2d};
        p1y = n1;
        p2y = n2;
        case (fault_mode)
            1: p1y = 1'b1;
            2: p2y = 1'b0;
            3: begin
                p1y = n2;
                p2y = n1;
            end
            4: p1y = ({p1a, p1b, p1c, p1d} == 4'h7) ? ~n1 : n1;
            default: ;
        endcase
    end

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Select the fault, record the expected verdict and pulse start so it
    // is sampled on the next rising edge; returns on the following negedge.
    task automatic applyStimulus(input run_t r);
        fault_mode = r.mode;
        exp_q.push_back(r);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then compare the reported verdict against the
    // oldest scoreboard entry, plus latency, held pins and pulse width.
    task automatic checkOutput();
        run_t r;
        int   cycles = 0;
        bit   seen = 1'b0;
        r = exp_q.pop_front();
        while (!seen && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            compareValue({r.name, " done timeout"}, 32'(cycles), 32'(RUN_CYCLES));
            return;
        end
        compareValue({r.name, " latency"},   32'(cycles),    32'(RUN_CYCLES));
        compareValue({r.name, " err_count"}, 32'(err_count), 32'(r.err));
        compareValue({r.name, " fail_vec"},  32'(fail_vec),  32'(r.fvec));
        compareValue({r.name, " fail_y"},    32'(fail_y),    32'(r.fy));
        compareValue({r.name, " pass"},      32'(pass),      32'(r.pass));
        compareValue({r.name, " busy"},      32'(busy),      32'(0));
        compareValue({r.name, " p1 pins"},   32'({p1a, p1b, p1c, p1d}), 32'(4'hF));
        compareValue({r.name, " p2 pins"},   32'({p2a, p2b, p2c, p2d}), 32'(4'h0));
        @(negedge clk);
        compareValue({r.name, " done width"}, 32'(done), 32'(0));
        compareValue({r.name, " pass held"},  32'(pass), 32'(r.pass));
    endtask

    initial begin
        runs[0] = '{mode: 0, name: "ideal",     err: 5'd0,  fvec: 4'd0,  fy: 2'b00, pass: 1'b1};
        runs[1] = '{mode: 1, name: "p1y_sa1",   err: 5'd1,  fvec: 4'd15, fy: 2'b11, pass: 1'b0};
        runs[2] = '{mode: 2, name: "p2y_sa0",   err: 5'd15, fvec: 4'd1,  fy: 2'b01, pass: 1'b0};
        runs[3] = '{mode: 3, name: "swapped",   err: 5'd2,  fvec: 4'd0,  fy: 2'b10, pass: 1'b0};
        runs[4] = '{mode: 4, name: "glitch_v7", err: 5'd1,  fvec: 4'd7,  fy: 2'b10, pass: 1'b0};
        runs[5] = '{mode: 0, name: "ideal2",    err: 5'd0,  fvec: 4'd0,  fy: 2'b00, pass: 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        compareValue("reset busy",      32'(busy),      32'(0));
        compareValue("reset done",      32'(done),      32'(0));
        compareValue("reset pass",      32'(pass),      32'(0));
        compareValue("reset err_count", 32'(err_count), 32'(0));
        compareValue("reset fail_vec",  32'(fail_vec),  32'(0));
        compareValue("reset fail_y",    32'(fail_y),    32'(0));
        compareValue("reset pins",      32'({p1a, p1b, p1c, p1d, p2a, p2b, p2c, p2d}), 32'(0));
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(runs[i]);
            checkOutput();
        end

        // Reset mid-run: p2y stuck-at-0 has failed vectors 1..5 by cycle 40.
        fault_mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        compareValue("midrun busy",      32'(busy),      32'(1));
        compareValue("midrun err_count", 32'(err_count), 32'(5));
        compareValue("midrun fail_vec",  32'(fail_vec),  32'(1));
        reset = 1'b1;
        #1;
        compareValue("abort busy",      32'(busy),      32'(0));
        compareValue("abort err_count", 32'(err_count), 32'(0));
        compareValue("abort fail_vec",  32'(fail_vec),  32'(0));
        compareValue("abort pins",      32'({p1a, p1b, p1c, p1d, p2a, p2b, p2c, p2d}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(runs[0]);
        checkOutput();

        // Start held high: back-to-back runs, DONE cycle plus one IDLE cycle
        // between them.
        fault_mode = 0;
        done_q.push_back(RUN_CYCLES);
        done_q.push_back(2 * RUN_CYCLES + 2);
        done_q.push_back(3 * RUN_CYCLES + 4);
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done) begin
                if (done_q.size() == 0) begin
                    compareValue("held unexpected done", 32'(c), 32'(0));
                end else begin
                    compareValue("held done cycle", 32'(c), 32'(done_q.pop_front()));
                    compareValue("held pass", 32'(pass), 32'(1));
                end
            end
        end
        compareValue("held missing dones", 32'(done_q.size()), 32'(0));
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        compareValue("final busy", 32'(busy), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
